// File: rtl/shift_add_mult.sv
// 16x16 unsigned sequential multiplier: one conditional add plus one right shift per cycle.
// A start accepted in IDLE gives the product 16 RUN cycles later, flagged by a single DONE cycle.

module rippleCA (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout
);
    logic [16:0] w_carry;

    assign w_carry[0] = i_cin;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_fa
            assign o_sum[gi]       = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
            assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_cout = w_carry[16];
endmodule

module shift_add_mult (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_m;
    logic [15:0] r_hi;
    logic [15:0] r_lo;
    logic [3:0]  r_cnt;
    logic [31:0] r_product;

    logic [15:0] w_addend;
    logic [15:0] w_sum;
    logic        w_c16;
    logic [31:0] w_shifted;
    logic        w_last;

    assign w_addend  = r_lo[0] ? r_m : 16'd0;
    // The adder carry becomes the new top bit, so no partial-product bit is lost on the shift.
    assign w_shifted = {w_c16, w_sum, r_lo[15:1]};
    assign w_last    = (r_cnt == 4'd15);

    rippleCA u_adder (
        .i_a    (r_hi),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_c16)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m       <= 16'd0;
            r_hi      <= 16'd0;
            r_lo      <= 16'd0;
            r_cnt     <= 4'd0;
            r_product <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m   <= a;
                        r_hi  <= 16'd0;
                        r_lo  <= b;
                        r_cnt <= 4'd0;
                    end
                end
                S_RUN: begin
                    {r_hi, r_lo} <= w_shifted;
                    r_cnt        <= r_cnt + 4'd1;
                    if (w_last) begin
                        r_product <= w_shifted;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product = r_product;
endmodule

// File: tb/tb_shift_add_mult.sv
// Randomized scoreboard bench for shift_add_mult: expected products come from plain a*b,
// a monitor pops them on every done pulse, and tasks check timing, hold and reset behaviour.

module tb_shift_add_mult;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a     = 16'd0;
    logic [15:0] b     = 16'd0;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_prod = 32'd0;

    shift_add_mult dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model_mul(input logic [15:0] x, input logic [15:0] y);
        return 32'(x) * 32'(y);
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_done_exclusive", 32'(busy & done), 32'd0);
            if (done) begin
                check("done_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("scoreboard_product", product, exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_mult(input logic [15:0] ia, input logic [15:0] ib, input string tag);
        int          k;
        logic        hold_ok;
        logic [31:0] expv;
        expv  = model_mul(ia, ib);
        a     = ia;
        b     = ib;
        start = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        start   = 1'b0;
        hold_ok = 1'b1;
        k       = 0;
        while (!done && k < 40) begin
            if (!busy || product !== last_prod) hold_ok = 1'b0;
            a = 16'($urandom);
            b = 16'($urandom);
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_done_latency"}, 32'(k), 32'd16);
        check({tag, "_busy_and_hold"}, 32'(hold_ok), 32'd1);
        check({tag, "_product"}, product, expv);
        if (!done) exp_q.delete();
        $display("txn %s a=0x%04h b=0x%04h product=0x%08h expected=0x%08h edges=%0d", tag, ia, ib, product, expv, k);
        last_prod = expv;
        @(posedge clk);
        #1;
        check({tag, "_idle_after"}, 32'({busy, done}), 32'd0);
    endtask

    task automatic ignored_start_test();
        int pos[$];
        a     = 16'd7;
        b     = 16'd9;
        start = 1'b1;
        exp_q.push_back(model_mul(16'd7, 16'd9));
        @(posedge clk);
        #1;
        for (int e = 1; e <= 36; e++) begin
            @(posedge clk);
            #1;
            if (done) pos.push_back(e);
            if (e == 17) check("held_start_idle_after_done", 32'(busy), 32'd0);
            if (e == 19) check("held_start_reaccept", 32'(busy), 32'd1);
            if (e == 5) begin
                a = 16'd3;
                b = 16'd4;
                exp_q.push_back(model_mul(16'd3, 16'd4));
            end
            if (e == 18) begin
                start = 1'b0;
                a     = 16'($urandom);
                b     = 16'($urandom);
            end
        end
        check("held_start_done_count", 32'(pos.size()), 32'd2);
        if (pos.size() == 2) begin
            check("held_start_done1_edge", 32'(pos[0]), 32'd16);
            check("held_start_done2_edge", 32'(pos[1]), 32'd34);
        end
        check("held_start_final_product", product, 32'd12);
        $display("txn held_start dones=%0d product=0x%08h", pos.size(), product);
        last_prod = 32'd12;
    endtask

    task automatic reset_mid_run_test();
        logic saw_done;
        a     = 16'hABCD;
        b     = 16'h1234;
        start = 1'b1;
        exp_q.push_back(model_mul(16'hABCD, 16'h1234));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_async_busy", 32'(busy), 32'd0);
        check("reset_async_done", 32'(done), 32'd0);
        check("reset_async_product", product, 32'd0);
        exp_q.delete();
        last_prod = 32'd0;
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("no_activity_after_reset", 32'(saw_done), 32'd0);
        $display("txn reset_mid_run product=0x%08h", product);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation_time_exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", product, 32'd0);
        rst_n = 1'b1;

        do_mult(16'd3, 16'd5, "basic");
        do_mult(16'hFFFF, 16'hFFFF, "max");
        do_mult(16'h1234, 16'h0000, "zero_b");
        do_mult(16'h0000, 16'hFFFF, "zero_a");
        ignored_start_test();
        reset_mid_run_test();
        do_mult(16'd2, 16'h8000, "after_reset");
        do_mult(16'd10, 16'd10, "hold_first");
        do_mult(16'd1, 16'd1, "hold_second");

        for (int i = 0; i < 20; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            do_mult(ra, rb, "random");
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
